// File: rtl/rv32_pipeline_pkg.sv
// Shared types and constants for the RV32 pipeline.
//   RV32_NOP       canonical NOP encoding (addi x0, x0, 0)
//   INSTR_BYTES    fetch stride in bytes
//   fetch_entry_t  fetch-to-decode payload {pc, instr}
//   mis_state_t    misaligned-redirect tracking states (used only when
//                  PL_RV32_FETCH_MISALIGN_CHECK_EN is defined)
package rv32_pipeline_pkg;

    localparam logic [31:0] RV32_NOP    = 32'h0000_0013;
    localparam int unsigned INSTR_BYTES = 4;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    typedef enum logic [1:0] {
        MIS_OFF,
        MIS_WAIT,
        MIS_SHOW
    } mis_state_t;

endpackage

// File: rtl/pl_rv32_fetch_fifo.sv
// Fetch buffer: synchronous FIFO of fetch_entry_t.
//   clk, rst    clock, synchronous active-high reset
//   flush       empties the FIFO; wins over push/pop in the same cycle
//   push        write push_data (accepted when not full, or full with pop)
//   pop         drop the head entry (ignored when empty)
//   head        current head entry (undefined content when empty)
//   count       number of stored entries
//   full/empty  status flags
module pl_rv32_fetch_fifo
    import rv32_pipeline_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  fetch_entry_t     push_data,
    input  logic             pop,
    output fetch_entry_t     head,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    fetch_entry_t     mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             pop_en;
    logic             push_en;

    assign empty   = (count == '0);
    assign full    = (32'(count) == DEPTH);
    assign pop_en  = pop && !empty;
    // A full FIFO can still take a push when the head leaves in the same cycle.
    assign push_en = push && (!full || pop_en);
    assign head    = mem[rd_ptr];

    // Pointers and occupancy; DEPTH is a power of two so pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_en) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop_en)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(push_en) - CNT_W'(pop_en);
        end
    end

    // Storage, not reset.
    always_ff @(posedge clk) begin
        if (push_en && !flush && !rst) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/pl_rv32_fetch.sv
// RV32 instruction fetch stage: keeps the fetch PC, issues word requests to
// instruction memory under a credit limit, buffers in-order responses and
// hands {pc, instr} to decode with valid/ready. Redirects flush the buffer
// and discard responses still in flight.
//   clk, rst                     clock, synchronous active-high reset
//   imem_req_valid/ready/addr    request channel (word aligned address)
//   imem_rsp_valid/data          in-order responses, one per accepted request
//   id_valid/ready/instr/pc      decode hand-off
//   redirect_valid/pc            taken branch/jump, single-cycle pulse
// Optional macro PL_RV32_FETCH_MISALIGN_CHECK_EN adds id_misaligned: a
// misaligned redirect target produces one NOP entry flagged misaligned and
// fetch idles until the next redirect. Without it redirect_pc[1:0] is ignored.
module pl_rv32_fetch
    import rv32_pipeline_pkg::*;
#(
    parameter logic [31:0] RESET_PC        = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH      = 2,
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
`ifdef PL_RV32_FETCH_MISALIGN_CHECK_EN
    output logic        id_misaligned,
`endif
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc
);

    localparam int unsigned OUT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

    logic [31:0]      fetch_pc;
    logic [31:0]      rsp_pc;
    logic [31:0]      redirect_target;
    logic [OUT_W-1:0] outstanding;
    logic [OUT_W-1:0] drop_cnt;
    logic [CNT_W-1:0] fifo_count;
    logic             fifo_full;
    logic             fifo_empty;
    fetch_entry_t     fifo_head;
    fetch_entry_t     fifo_wdata;
    logic             req_ok;
    logic             req_fire;
    logic             rsp_keep;
    logic             fifo_push;
    logic             fifo_pop;
    logic             mis_block;
    logic             mis_push;

    assign redirect_target = {redirect_pc[31:2], 2'b00};

    // Credit check: never have more requests in flight than the FIFO can absorb.
    assign req_ok = !rst && !redirect_valid && !mis_block
                 && (32'(outstanding) < MAX_OUTSTANDING)
                 && ((32'(outstanding) + 32'(fifo_count)) < FIFO_DEPTH);
    assign req_fire = req_ok && imem_req_ready;

    assign imem_req_valid = req_ok;
    assign imem_req_addr  = rst ? RESET_PC : fetch_pc;

    // Responses owed to a pre-redirect PC stream are dropped via drop_cnt.
    assign rsp_keep  = imem_rsp_valid && (drop_cnt == '0) && !redirect_valid;
    assign fifo_push = rsp_keep || mis_push;
    assign fifo_pop  = id_ready && !fifo_empty;

    assign id_valid = !rst && !fifo_empty;
    assign id_pc    = rst ? '0 : fifo_head.pc;
    assign id_instr = rst ? '0 : fifo_head.instr;

`ifdef PL_RV32_FETCH_MISALIGN_CHECK_EN
    mis_state_t  mis_state;
    mis_state_t  mis_state_nxt;
    logic [31:0] mis_pc;

    // Misaligned-redirect state register and raw target capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            mis_state <= MIS_OFF;
            mis_pc    <= '0;
        end else begin
            mis_state <= mis_state_nxt;
            if (redirect_valid) mis_pc <= redirect_pc;
        end
    end

    // Wait for stale responses to drain, then inject exactly one NOP entry.
    always_comb begin
        mis_state_nxt = mis_state;
        mis_push      = 1'b0;
        if (redirect_valid) begin
            mis_state_nxt = (redirect_pc[1:0] != 2'b00) ? MIS_WAIT : MIS_OFF;
        end else if ((mis_state == MIS_WAIT) && (drop_cnt == '0)) begin
            mis_state_nxt = MIS_SHOW;
            mis_push      = 1'b1;
        end
    end

    assign mis_block = (mis_state != MIS_OFF);

    always_comb begin
        fifo_wdata = '{pc: rsp_pc, instr: imem_rsp_data};
        if (mis_push) fifo_wdata = '{pc: mis_pc, instr: RV32_NOP};
    end

    assign id_misaligned = !rst && (mis_state == MIS_SHOW) && !fifo_empty;
`else
    logic unused_redirect_lsbs;

    assign mis_block            = 1'b0;
    assign mis_push             = 1'b0;
    assign fifo_wdata           = '{pc: rsp_pc, instr: imem_rsp_data};
    assign unused_redirect_lsbs = ^redirect_pc[1:0];
`endif

    // PC tracking, in-flight count and drop count; redirect overrides all.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc    <= RESET_PC;
            rsp_pc      <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
        end else begin
            outstanding <= outstanding + OUT_W'(req_fire) - OUT_W'(imem_rsp_valid);
            if (redirect_valid) begin
                fetch_pc <= redirect_target;
                rsp_pc   <= redirect_target;
                drop_cnt <= outstanding - OUT_W'(imem_rsp_valid);
            end else begin
                if (req_fire) fetch_pc <= fetch_pc + 32'(INSTR_BYTES);
                if (imem_rsp_valid) begin
                    if (drop_cnt != '0) drop_cnt <= drop_cnt - OUT_W'(1);
                    else                rsp_pc   <= rsp_pc + 32'(INSTR_BYTES);
                end
            end
        end
    end

    pl_rv32_fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (redirect_valid),
        .push      (fifo_push),
        .push_data (fifo_wdata),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // The credit rule makes a push into a full, non-popping FIFO impossible.
    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(fifo_push && !redirect_valid && fifo_full && !fifo_pop));

endmodule

// File: tb/tb_pl_rv32_fetch.sv
// Self-checking bench for pl_rv32_fetch: a behavioural memory with
// programmable latency, a queue-based reference model checked every cycle,
// and directed scenarios with literal expectations.
module tb_pl_rv32_fetch;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          DEPTH    = 2;
    localparam int          MAXO     = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b1;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data  = '0;
    logic        id_valid;
    logic        id_ready = 1'b1;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc    = '0;
`ifdef PL_RV32_FETCH_MISALIGN_CHECK_EN
    logic        id_misaligned;
`endif

    pl_rv32_fetch dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .id_valid       (id_valid),
        .id_ready       (id_ready),
        .id_instr       (id_instr),
        .id_pc          (id_pc),
`ifdef PL_RV32_FETCH_MISALIGN_CHECK_EN
        .id_misaligned  (id_misaligned),
`endif
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] pc; int ep; } req_t;
    typedef struct { logic [31:0] pc; logic [31:0] instr; bit mis; } ent_t;
    typedef struct { logic [31:0] addr; int due; } mem_t;

    int          n_vec = 0;
    int          n_err = 0;
    int          cyc   = 0;
    int          mem_lat = 1;
    int          epoch = 0;
    logic [31:0] m_pc  = RESET_PC;
    bit          mis_mode = 1'b0;
    bit          mis_wait = 1'b0;
    logic [31:0] mis_pc   = '0;
    req_t        out_q[$];
    ent_t        buf_q[$];
    mem_t        mem_q[$];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hDEAD_0000;
    endfunction

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    function automatic void chk1(input string name, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
        end
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Memory: in-order responses, each no earlier than its due cycle.
    always @(posedge clk) begin
        #1;
        if (mem_q.size() != 0 && mem_q[0].due <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(mem_q[0].addr);
            void'(mem_q.pop_front());
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = '0;
        end
    end

    // Reference model: compare outputs, then advance across the coming edge.
    always @(negedge clk) begin : model_p
        bit   exp_req;
        bit   push_mis;
        req_t o;
        mem_t m;
        ent_t e;
        exp_req = !rst && !redirect_valid && !mis_mode
               && (out_q.size() < MAXO) && (out_q.size() + buf_q.size() < DEPTH);
        chk1("req_valid", imem_req_valid, exp_req);
        chk1("id_valid", id_valid, !rst && (buf_q.size() != 0));
        if (rst) begin
            chk("rst_req_addr", imem_req_addr, RESET_PC);
            chk("rst_id_pc", id_pc, 32'h0);
            chk("rst_id_instr", id_instr, 32'h0);
`ifdef PL_RV32_FETCH_MISALIGN_CHECK_EN
            chk1("rst_id_misaligned", id_misaligned, 1'b0);
`endif
            out_q.delete();
            buf_q.delete();
            mem_q.delete();
            m_pc     = RESET_PC;
            mis_mode = 1'b0;
            mis_wait = 1'b0;
        end else begin
            if (exp_req) chk("req_addr", imem_req_addr, m_pc);
            if (buf_q.size() != 0) begin
                chk("id_pc", id_pc, buf_q[0].pc);
                chk("id_instr", id_instr, buf_q[0].instr);
            end
`ifdef PL_RV32_FETCH_MISALIGN_CHECK_EN
            chk1("id_misaligned", id_misaligned, (buf_q.size() != 0) && buf_q[0].mis);
`endif
            if (imem_req_valid && imem_req_ready) begin
                m.addr = imem_req_addr;
                m.due  = cyc + mem_lat;
                mem_q.push_back(m);
            end
            if (imem_rsp_valid) chk1("rsp_has_request", out_q.size() != 0, 1'b1);
            if (redirect_valid) begin
                epoch++;
                if (imem_rsp_valid && out_q.size() != 0) void'(out_q.pop_front());
                buf_q.delete();
                m_pc     = {redirect_pc[31:2], 2'b00};
                mis_mode = 1'b0;
                mis_wait = 1'b0;
`ifdef PL_RV32_FETCH_MISALIGN_CHECK_EN
                mis_mode = (redirect_pc[1:0] != 2'b00);
                mis_wait = mis_mode;
                mis_pc   = redirect_pc;
`endif
            end else begin
                push_mis = mis_wait && (out_q.size() == 0);
                if (push_mis) mis_wait = 1'b0;
                if (id_ready && buf_q.size() != 0) void'(buf_q.pop_front());
                if (exp_req && imem_req_ready) begin
                    o.pc = m_pc;
                    o.ep = epoch;
                    out_q.push_back(o);
                    m_pc = m_pc + 32'd4;
                end
                if (imem_rsp_valid && out_q.size() != 0) begin
                    o = out_q.pop_front();
                    if (o.ep == epoch) begin
                        e.pc = o.pc; e.instr = mem_word(o.pc); e.mis = 1'b0;
                        buf_q.push_back(e);
                    end
                end
                if (push_mis) begin
                    e.pc = mis_pc; e.instr = 32'h0000_0013; e.mis = 1'b1;
                    buf_q.push_back(e);
                end
                chk1("outstanding_bound", out_q.size() <= MAXO, 1'b1);
                chk1("buffer_bound", buf_q.size() <= DEPTH, 1'b1);
            end
        end
    end

    // Caller is just after a rising edge; pulse lasts exactly one cycle.
    task automatic pulse_redirect(input logic [31:0] pc);
        redirect_pc    = pc;
        redirect_valid = 1'b1;
        @(posedge clk);
        #1;
        redirect_valid = 1'b0;
    endtask

    task automatic wait_id(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (id_valid) begin
                ok = 1'b1;
                return;
            end
        end
    endtask

    initial begin
        bit          ok;
        int          n;
        logic [31:0] got [3];

        // Reset, then 1-cycle memory with decode always ready.
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk1("t1_req_valid", imem_req_valid, 1'b1);
        chk("t1_req_addr", imem_req_addr, 32'h0000_0000);
        chk1("t1_idv_c0", id_valid, 1'b0);
        @(negedge clk);
        chk1("t1_idv_c1", id_valid, 1'b0);
        @(negedge clk);
        chk1("t1_idv_c2", id_valid, 1'b1);
        chk("t1_pc0", id_pc, 32'h0000_0000);
        chk("t1_instr0", id_instr, 32'hDEAD_0000);
        repeat (8) @(posedge clk);

        // Decode stall: buffer fills, requests stop, then drain.
        #1 id_ready = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        chk1("t2_stall_idv", id_valid, 1'b1);
        chk1("t2_stall_noreq", imem_req_valid, 1'b0);
        @(posedge clk);
        #1 id_ready = 1'b1;
        repeat (10) @(posedge clk);

        // 3-cycle latency; redirect while two requests are in flight.
        #1 mem_lat = 3;
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk);
            #2;
            if (out_q.size() == 2 && !imem_rsp_valid) begin
                ok = 1'b1;
                break;
            end
        end
        chk1("t3_two_in_flight", ok, 1'b1);
        pulse_redirect(32'h0000_0100);
        wait_id(ok);
        chk1("t3_idv_timeout", ok, 1'b1);
        chk("t3_pc", id_pc, 32'h0000_0100);
        chk("t3_instr", id_instr, 32'hDEAD_0100);

        // Redirect coinciding with a response and a decode pop.
        @(posedge clk);
        #1 mem_lat = 1;
        repeat (6) @(posedge clk);
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk);
            #2;
            if (imem_rsp_valid && id_valid) begin
                ok = 1'b1;
                break;
            end
        end
        chk1("t4_rsp_and_pop", ok, 1'b1);
        pulse_redirect(32'h0000_0240);
        @(negedge clk);
        chk1("t4_flushed", id_valid, 1'b0);
        chk1("t4_req_valid", imem_req_valid, 1'b1);
        chk("t4_req_addr", imem_req_addr, 32'h0000_0240);
        repeat (6) @(posedge clk);

        // Address wrap at the top of the address space.
        #1;
        pulse_redirect(32'hFFFF_FFF8);
        n = 0;
        got[0] = '0; got[1] = '0; got[2] = '0;
        for (int i = 0; i < 40 && n < 3; i++) begin
            @(negedge clk);
            if (imem_req_valid && imem_req_ready) begin
                got[n] = imem_req_addr;
                n++;
            end
        end
        chk("t5_count", 32'(n), 32'd3);
        chk("t5_addr0", got[0], 32'hFFFF_FFF8);
        chk("t5_addr1", got[1], 32'hFFFF_FFFC);
        chk("t5_addr2", got[2], 32'h0000_0000);
        repeat (8) @(posedge clk);

`ifdef PL_RV32_FETCH_MISALIGN_CHECK_EN
        // Misaligned target: one flagged NOP, then silence until realigned.
        #1;
        pulse_redirect(32'h0000_0102);
        wait_id(ok);
        chk1("t6_idv_timeout", ok, 1'b1);
        chk1("t6_misaligned", id_misaligned, 1'b1);
        chk("t6_pc", id_pc, 32'h0000_0102);
        chk("t6_instr", id_instr, 32'h0000_0013);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk1("t6_noreq", imem_req_valid, 1'b0);
        end
        @(posedge clk);
        #1;
        pulse_redirect(32'h0000_0200);
        wait_id(ok);
        chk1("t6_idv2_timeout", ok, 1'b1);
        chk("t6_pc2", id_pc, 32'h0000_0200);
        chk1("t6_aligned", id_misaligned, 1'b0);
        repeat (4) @(posedge clk);
`endif

        // Reset in the middle of traffic.
        #1 mem_lat = 3;
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk1("t7_rst_req", imem_req_valid, 1'b0);
        chk1("t7_rst_idv", id_valid, 1'b0);
        chk("t7_rst_addr", imem_req_addr, RESET_PC);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        wait_id(ok);
        chk1("t7_idv_timeout", ok, 1'b1);
        chk("t7_pc", id_pc, 32'h0000_0000);
        chk("t7_instr", id_instr, 32'hDEAD_0000);
        repeat (5) @(posedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d miscompares so far", n_err);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
        $fatal(1);
    end

endmodule

// File: doc/pl_rv32_fetch.md
Name: pl_rv32_fetch

Overview:
Instruction fetch stage of the pipelined RV32 core, and the producer end of the fetch-to-decode hand-off that the controller consumes.
- Keeps the fetch PC and issues word requests to instruction memory.
- Accepts in-order responses of variable latency and buffers them in a small FIFO.
- Presents {pc, instr} to decode with a valid/ready handshake.
- Branch/jump redirects flush the FIFO and discard in-flight responses.

Parameters:
RESET_PC, 32'h0000_0000, fetch address after reset
FIFO_DEPTH, 2, fetch buffer entries (power of two, >=2)
MAX_OUTSTANDING, 2, maximum accepted-but-unanswered imem requests (>=1)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous, active-high reset
imem_req_valid  out  1  request valid
imem_req_ready  in  1  memory accepts request
imem_req_addr  out  32  word address (bits[1:0]=0)
imem_rsp_valid  in  1  response valid, one per accepted request, in order
imem_rsp_data  in  32  instruction word
id_valid  out  1  decode entry valid
id_ready  in  1  decode consumes entry (low = stall)
id_instr  out  32  instruction to decode
id_pc  out  32  PC of id_instr
redirect_valid  in  1  branch/jump taken, single-cycle pulse
redirect_pc  in  32  new fetch target

Behaviour:
- Reset:
  - fetch_pc=RESET_PC, rsp_pc=RESET_PC; outstanding, drop_cnt and fifo_count are 0.
  - Outputs while rst=1: imem_req_valid=0, id_valid=0, imem_req_addr=RESET_PC, id_instr=0, id_pc=0.
  - Reset mid-operation discards all buffered and in-flight state. Any responses arriving after reset are the memory's responsibility; the memory is reset together with this block.
- Issue:
  - imem_req_valid = !rst && !redirect_valid && outstanding < MAX_OUTSTANDING && (outstanding + fifo_count) < FIFO_DEPTH.
  - imem_req_addr = fetch_pc. On valid&&ready: fetch_pc += 4 (32-bit wrap, 0xFFFF_FFFC -> 0), outstanding++.
  - imem_req_valid is not sticky; it may drop without acceptance only on a redirect cycle.
- Response:
  - Each imem_rsp_valid does outstanding--.
  - If drop_cnt>0: drop_cnt--, data discarded.
  - Otherwise: push {rsp_pc, imem_rsp_data} into the FIFO, then rsp_pc += 4.
  - The credit rule guarantees the FIFO never overflows. A push into a full FIFO is an assertion failure.
  - Simultaneous accept and response in one cycle: outstanding is unchanged.
- Decode side:
  - id_valid = fifo_count != 0; id_pc/id_instr come from the FIFO head.
  - Pop on id_valid && id_ready.
  - Push and pop in the same cycle are allowed, including when the FIFO is full.
  - With id_ready=0, entries hold stable.
  - Minimum latency: request accepted in cycle N, response in N+1, id_valid in N+2.
- Redirect (highest priority):
  - fetch_pc <= {redirect_pc[31:2],2'b00} and rsp_pc <= the same value. The FIFO is flushed; any same-cycle pop is ignored.
  - drop_cnt <= outstanding - (imem_rsp_valid ? 1 : 0). A response arriving in the redirect cycle is itself discarded.
  - No request is issued in the redirect cycle; fetch from the new PC starts the next cycle.
  - Back-to-back redirects: the last one wins. drop_cnt is recomputed from outstanding each time.

Optional Feature:
Macro: PL_RV32_FETCH_MISALIGN_CHECK_EN.
- Defined:
  - Adds output id_misaligned (1 bit, reset 0).
  - A redirect with redirect_pc[1:0]!=0 flushes as normal, then issues no requests.
  - Once drop_cnt reaches 0, it presents one entry: id_pc=redirect_pc unmodified, id_instr=RV32_NOP, id_misaligned=1.
  - It then idles until the next redirect.
- Undefined: no port; redirect_pc[1:0] is silently forced to 00.

Decomposition:
- rv32_pipeline_pkg gains:
  - RV32_NOP = 32'h0000_0013.
  - fetch_entry_t packed struct {logic [31:0] pc; logic [31:0] instr;}.
  - INSTR_BYTES = 4.
- Sub-module pl_rv32_fetch_fifo: synchronous FIFO of fetch_entry_t with push, pop, flush, count and full/empty. Flush has priority over push/pop.

Test Plan:
- Reset then imem always ready with 1-cycle latency, id_ready=1 -> requests 0x0,0x4,0x8...; id_pc sequence 0x0,0x4,0x8 each with the matching data; first id_valid 2 cycles after reset release.
- id_ready=0 for 10 cycles -> FIFO fills to 2 and imem_req_valid goes low; outstanding never exceeds 2; release -> entries drain in order, none lost or duplicated.
- 3-cycle response latency with 2 outstanding, redirect_pc=0x100 -> both old responses dropped (drop_cnt=2); next id_pc=0x100.
- Redirect in the same cycle as a response and as an id pop -> that response is discarded, the FIFO is empty the next cycle, first new request has addr=target.
- fetch_pc=0xFFFF_FFF8 sequence -> addresses 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
- With PL_RV32_FETCH_MISALIGN_CHECK_EN, redirect_pc=0x102 -> a single entry with id_misaligned=1, id_pc=0x102, id_instr=0x13, then no requests until redirect_pc=0x200.
